// File: rtl/baud_divisor_ctrl.sv
// Divisor update controller for the UART baud generator: range-checks host requests and
// swaps the divisor right after a baud rising edge, then holds the generator in reset for a
// settle window. Define BAUD_AUTOBAUD_EN to add rx-based autobaud measurement.
module baud_divisor_ctrl #(
  parameter int              DIV_W         = 12,
  parameter logic [DIV_W-1:0] DEFAULT_DIV  = 12'd325,
  parameter logic [DIV_W-1:0] MIN_DIV      = 12'd2,
  parameter int              SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_divisor,
  output logic             cfg_ready,
  input  logic             baud_in,
  output logic [DIV_W-1:0] divisor_out,
  output logic             gen_reset,
  output logic             busy,
  output logic             update_done,
  output logic             cfg_err,
  input  logic             err_clr
`ifdef BAUD_AUTOBAUD_EN
  ,
  input  logic             rx,
  input  logic             ab_start,
  output logic             ab_active
`endif
);

  localparam int CNT_W = DIV_W + 2;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((1 << (DIV_W + 1)) - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT_EDGE,
    S_HOLD,
    S_RELEASE
`ifdef BAUD_AUTOBAUD_EN
    ,
    S_AB_FALL,
    S_AB_MEAS
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   staging_q, staging_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               err_q, err_d;
  logic               baud_q;
  logic               gen_reset_q, gen_reset_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               update_done_q, update_done_d;
  logic               baud_rise;

  assign baud_rise = baud_in & ~baud_q;

`ifdef BAUD_AUTOBAUD_EN
  logic               rx_meta_q, rx_sync_q, rx_prev_q;
  logic               rx_fall, rx_rise;
  logic [DIV_W:0]     ab_cnt_q, ab_cnt_d;
  logic [DIV_W:0]     ab_half;
  logic [DIV_W-1:0]   ab_div;
  logic               ab_active_q, ab_active_d;

  assign rx_fall = ~rx_sync_q & rx_prev_q;
  assign rx_rise = rx_sync_q & ~rx_prev_q;
  assign ab_half = ab_cnt_q >> 1;

  // Measured low time spans two bit periods' worth of half-counts; clamp into the legal range.
  always_comb begin
    ab_div = MIN_DIV;
    if (ab_half >= ({1'b0, MIN_DIV} + (DIV_W+1)'(1))) begin
      if ((ab_half - (DIV_W+1)'(1)) > {1'b0, {DIV_W{1'b1}}}) ab_div = {DIV_W{1'b1}};
      else                                                   ab_div = DIV_W'(ab_half - (DIV_W+1)'(1));
    end
  end
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    staging_d = staging_q;
    div_d     = div_q;
    err_d     = err_q;
`ifdef BAUD_AUTOBAUD_EN
    ab_cnt_d  = ab_cnt_q;
`endif
    if (err_clr) err_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
`ifdef BAUD_AUTOBAUD_EN
        if (ab_start) begin
          state_d = S_AB_FALL;
        end else
`endif
        if (cfg_valid && cfg_ready_q) begin
          if (cfg_divisor < MIN_DIV) begin
            err_d = 1'b1;  // set wins over a simultaneous err_clr
          end else begin
            staging_d = cfg_divisor;
            state_d   = S_WAIT_EDGE;
            cnt_d     = '0;
          end
        end
      end
      S_WAIT_EDGE: begin
        if (baud_rise || (cnt_q == TIMEOUT_LAST)) begin
          state_d = S_HOLD;
          div_d   = staging_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
`ifdef BAUD_AUTOBAUD_EN
      S_AB_FALL: begin
        if (rx_fall) begin
          state_d  = S_AB_MEAS;
          ab_cnt_d = (DIV_W+1)'(1);
        end
      end
      S_AB_MEAS: begin
        if (rx_rise) begin
          staging_d = ab_div;
          state_d   = S_WAIT_EDGE;
          cnt_d     = '0;
        end else if (!rx_sync_q && (ab_cnt_q != '1)) begin
          ab_cnt_d = ab_cnt_q + (DIV_W+1)'(1);
        end
      end
`endif
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    gen_reset_d   = (state_d == S_INIT) || (state_d == S_HOLD);
    cfg_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    update_done_d = (state_d == S_RELEASE);
`ifdef BAUD_AUTOBAUD_EN
    ab_active_d   = (state_d == S_AB_FALL) || (state_d == S_AB_MEAS);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      staging_q     <= DEFAULT_DIV;
      div_q         <= DEFAULT_DIV;
      err_q         <= 1'b0;
      baud_q        <= 1'b0;
      gen_reset_q   <= 1'b1;
      cfg_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      staging_q     <= staging_d;
      div_q         <= div_d;
      err_q         <= err_d;
      baud_q        <= baud_in;
      gen_reset_q   <= gen_reset_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      update_done_q <= update_done_d;
    end
  end

`ifdef BAUD_AUTOBAUD_EN
  // rx idles high, so the synchroniser resets to 1 to avoid a false falling edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      ab_cnt_q    <= '0;
      ab_active_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      ab_cnt_q    <= ab_cnt_d;
      ab_active_q <= ab_active_d;
    end
  end

  assign ab_active = ab_active_q;
`endif

  assign cfg_ready   = cfg_ready_q;
  assign divisor_out = div_q;
  assign gen_reset   = gen_reset_q;
  assign busy        = busy_q;
  assign update_done = update_done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_baud_divisor_ctrl.sv
// Self-checking bench for baud_divisor_ctrl: directed and randomized divisor updates against a
// behavioural model of the update sequence; define BAUD_AUTOBAUD_EN to also exercise autobaud.
module tb_baud_divisor_ctrl;

  localparam int          SETTLE  = 2;
  localparam logic [11:0] DEF_DIV = 12'd325;
  localparam logic [11:0] MIN_DIV = 12'd2;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [11:0] cfg_divisor = '0;
  logic        cfg_ready;
  logic        baud_in = 1'b0;
  logic [11:0] divisor_out;
  logic        gen_reset;
  logic        busy;
  logic        update_done;
  logic        cfg_err;
  logic        err_clr = 1'b0;
`ifdef BAUD_AUTOBAUD_EN
  logic        rx = 1'b1;
  logic        ab_start = 1'b0;
  logic        ab_active;
`endif

  baud_divisor_ctrl dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_divisor (cfg_divisor),
    .cfg_ready   (cfg_ready),
    .baud_in     (baud_in),
    .divisor_out (divisor_out),
    .gen_reset   (gen_reset),
    .busy        (busy),
    .update_done (update_done),
    .cfg_err     (cfg_err),
    .err_clr     (err_clr)
`ifdef BAUD_AUTOBAUD_EN
    ,
    .rx          (rx),
    .ab_start    (ab_start),
    .ab_active   (ab_active)
`endif
  );

  always #5 Clk = ~Clk;

  int          total = 0;
  int          bad = 0;
  logic [11:0] model_div;
  logic        model_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gen_reset"}, gen_reset, 1);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_update_done"}, update_done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_divisor"}, divisor_out, DEF_DIV);
  endtask

  // Called #1 after the edge at which reset_n was seen high.
  task automatic init_sequence();
    tick();
    check("init_gen_reset_held", gen_reset, 1);
    check("init_no_done_yet", update_done, 0);
    tick();
    check("init_release_gen_reset", gen_reset, 0);
    check("init_done_pulse", update_done, 1);
    check("init_divisor", divisor_out, DEF_DIV);
    tick();
    check("init_done_one_cycle", update_done, 0);
    check("init_cfg_ready", cfg_ready, 1);
    check("init_busy_low", busy, 0);
    model_div = DEF_DIV;
    model_err = 1'b0;
  endtask

  // Present a request; if legal, produce a baud rise sampled k edges after acceptance.
  task automatic host_update(input logic [11:0] div, input int k);
    logic quiet;
    check("pre_cfg_ready", cfg_ready, 1);
    cfg_valid   = 1'b1;
    cfg_divisor = div;
    tick();
    cfg_valid = 1'b0;
    if (div < MIN_DIV) begin
      model_err = 1'b1;
      check("rej_cfg_err", cfg_err, model_err);
      check("rej_cfg_ready", cfg_ready, 1);
      check("rej_no_gen_reset", gen_reset, 0);
      check("rej_divisor", divisor_out, model_div);
      return;
    end
    check("acc_cfg_ready_low", cfg_ready, 0);
    check("acc_busy", busy, 1);
    quiet = 1'b1;
    for (int i = 1; i < k; i++) begin
      if (gen_reset !== 1'b0 || divisor_out !== model_div) quiet = 1'b0;
      tick();
    end
    check("wait_quiet", {31'd0, quiet}, 1);
    check("wait_divisor_old", divisor_out, model_div);
    baud_in = 1'b1;
    tick();
    baud_in = 1'b0;
    model_div = div;
    check("hold_gen_reset", gen_reset, 1);
    check("hold_divisor_new", divisor_out, model_div);
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      check("hold_gen_reset_stays", gen_reset, 1);
      check("hold_no_done", update_done, 0);
    end
    tick();
    check("rel_gen_reset_low", gen_reset, 0);
    check("rel_done", update_done, 1);
    check("rel_divisor", divisor_out, model_div);
    tick();
    check("idle_done_low", update_done, 0);
    check("idle_busy_low", busy, 0);
    check("idle_cfg_ready", cfg_ready, 1);
  endtask

  initial begin
    logic [11:0] d;
    int          n;
    model_div = DEF_DIV;
    model_err = 1'b0;

    // Reset state, then power-up settle sequence.
    repeat (2) @(posedge Clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;
    init_sequence();

    // Directed update: rise 17 cycles after acceptance.
    host_update(12'd100, 17);

    // Rejection, then err_clr colliding with another rejection, then a plain clear.
    host_update(12'd1, 1);
    err_clr     = 1'b1;
    cfg_valid   = 1'b1;
    cfg_divisor = 12'd0;
    tick();
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    check("err_set_wins", cfg_err, 1);
    check("err_div_kept", divisor_out, model_div);
    err_clr = 1'b1;
    tick();
    err_clr   = 1'b0;
    model_err = 1'b0;
    check("err_cleared", cfg_err, model_err);

    // Boundary: smallest legal divisor, then equal divisor reruns the full sequence.
    host_update(MIN_DIV, 1);
    host_update(MIN_DIV, 4);

    // Randomized updates, some of them illegal.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) d = 12'($urandom_range(0, 1));
      else                           d = 12'($urandom_range(2, 4095));
      host_update(d, $urandom_range(1, 25));
      if (model_err) begin
        err_clr = 1'b1;
        tick();
        err_clr   = 1'b0;
        model_err = 1'b0;
        check("rand_err_cleared", cfg_err, model_err);
      end
    end

    // Stalled generator: timeout forces HOLD after 2^13 cycles.
    cfg_valid   = 1'b1;
    cfg_divisor = 12'd50;
    tick();
    cfg_valid = 1'b0;
    n = 0;
    while (gen_reset !== 1'b1 && n < 9000) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 8192);
    model_div = 12'd50;
    check("timeout_divisor", divisor_out, model_div);
    repeat (SETTLE) tick();
    check("timeout_done", update_done, 1);
    tick();
    check("timeout_idle", busy, 0);

    // Reset asserted during HOLD: everything reverts, staged value lost.
    cfg_valid   = 1'b1;
    cfg_divisor = 12'd200;
    tick();
    cfg_valid = 1'b0;
    tick();
    baud_in = 1'b1;
    tick();
    baud_in = 1'b0;
    check("mid_hold_entered", gen_reset, 1);
    check("mid_hold_divisor", divisor_out, 200);
    reset_n = 1'b0;
    #2;
    check_reset_values("midrst");
    @(posedge Clk);
    #1;
    check_reset_values("midrst_held");
    reset_n = 1'b1;
    init_sequence();

`ifdef BAUD_AUTOBAUD_EN
    // Autobaud: rx low for 868 cycles gives (868>>1)-1 = 433.
    begin
      int          low_n;
      int          half;
      logic [11:0] ab_exp;
      low_n  = 868;
      half   = low_n >> 1;
      ab_exp = (half - 1 < MIN_DIV) ? MIN_DIV : 12'(half - 1);
      ab_start = 1'b1;
      tick();
      ab_start = 1'b0;
      check("ab_active_high", ab_active, 1);
      check("ab_busy", busy, 1);
      repeat (3) tick();
      rx = 1'b0;
      repeat (low_n) tick();
      rx = 1'b1;
      n = 0;
      while (ab_active !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      check("ab_left_measure", {31'd0, (n < 20)}, 1);
      baud_in = 1'b1;
      tick();
      baud_in   = 1'b0;
      model_div = ab_exp;
      check("ab_hold_gen_reset", gen_reset, 1);
      check("ab_divisor", divisor_out, model_div);
      repeat (SETTLE) tick();
      check("ab_done", update_done, 1);
      check("ab_active_low", ab_active, 0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
